// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
// Bundles the functional-unit request side and the common-data-bus
// broadcast side of the CDB arbiter into one interface.
//
// Signals:
//   req[3:0]          FU i holds a completed result (held until granted)
//   tag0..tag3        result tag of each FU, stable while its req is high
//   data0..data3      result value of each FU, stable while its req is high
//   cdb_ready         consumers can take a broadcast next cycle
//   grant[3:0]        one-hot combinational grant back to the FUs
//   cdb_valid         registered broadcast strobe
//   cdb_sel[1:0]      registered index of the broadcasting FU
//   cdb_tag           registered broadcast tag
//   cdb_data          registered broadcast value
//   bcast_cnt[15:0]   saturating count of broadcasts since reset
//
// Modports:
//   master  the FU / consumer side (drives requests, observes the bus)
//   slave   the arbiter side
interface cdb_arbiter_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [3:0]        req;
  logic [TAG_W-1:0]  tag0;
  logic [TAG_W-1:0]  tag1;
  logic [TAG_W-1:0]  tag2;
  logic [TAG_W-1:0]  tag3;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic              cdb_ready;
  logic [3:0]        grant;
  logic              cdb_valid;
  logic [1:0]        cdb_sel;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [15:0]       bcast_cnt;

  modport master (
    output req, tag0, tag1, tag2, tag3, data0, data1, data2, data3, cdb_ready,
    input  grant, cdb_valid, cdb_sel, cdb_tag, cdb_data, bcast_cnt
  );

  modport slave (
    input  req, tag0, tag1, tag2, tag3, data0, data1, data2, data3, cdb_ready,
    output grant, cdb_valid, cdb_sel, cdb_tag, cdb_data, bcast_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Common-data-bus arbiter for the Tomasulo core. Picks one of up to four
// functional units holding a completed result each cycle, grants it
// combinationally and registers the broadcast (valid, sel, tag, data) one
// cycle later toward the reservation stations and register status table.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   cdb_arbiter_if.slave (requests, tags, data, cdb_ready in;
//         grant, cdb_valid, cdb_sel, cdb_tag, cdb_data, bcast_cnt out)
//
// Configuration macro:
//   CDB_ROUND_ROBIN_EN  defined   -> rotating priority via a 2-bit pointer
//                       undefined -> fixed priority, FU 0 highest
module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  // Highest-priority FU for this cycle's search.
  logic [1:0] ptr;

`ifdef CDB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 2'd0;
`endif

  logic              cdbValid_q, cdbValid_d;
  logic [1:0]        cdbSel_q,   cdbSel_d;
  logic [TAG_W-1:0]  cdbTag_q,   cdbTag_d;
  logic [DATA_W-1:0] cdbData_q,  cdbData_d;
  logic [15:0]       bcastCnt_q, bcastCnt_d;

  logic       found;
  logic [1:0] winnerIdx;
  logic [1:0] cand;
  logic       grantEn;

  logic [TAG_W-1:0]  winTag;
  logic [DATA_W-1:0] winData;

  // Walk ptr, ptr+1, ptr+2, ptr+3 (mod 4) and stop at the first requester.
  // The 2-bit add wraps naturally, so FU 3 is followed by FU 0.
  always_comb begin
    found     = 1'b0;
    winnerIdx = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && bus.req[cand]) begin
        found     = 1'b1;
        winnerIdx = cand;
      end
    end
  end

  // A grant needs a requester, room downstream and no reset this cycle.
  assign grantEn   = found & bus.cdb_ready & ~rst;
  assign bus.grant = grantEn ? (4'b0001 << winnerIdx) : 4'b0000;

  // Steer the winning FU's result onto the broadcast path.
  always_comb begin
    winTag  = bus.tag0;
    winData = bus.data0;
    case (winnerIdx)
      2'd0: begin winTag = bus.tag0; winData = bus.data0; end
      2'd1: begin winTag = bus.tag1; winData = bus.data1; end
      2'd2: begin winTag = bus.tag2; winData = bus.data2; end
      2'd3: begin winTag = bus.tag3; winData = bus.data3; end
      default: begin winTag = bus.tag0; winData = bus.data0; end
    endcase
  end

  // Next-state for the broadcast register. Without a grant the strobe
  // drops but sel/tag/data keep the last broadcast so consumers never see
  // stray values on an idle bus.
  always_comb begin
    cdbValid_d = grantEn;
    cdbSel_d   = cdbSel_q;
    cdbTag_d   = cdbTag_q;
    cdbData_d  = cdbData_q;
    bcastCnt_d = bcastCnt_q;
`ifdef CDB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    if (grantEn) begin
      cdbSel_d  = winnerIdx;
      cdbTag_d  = winTag;
      cdbData_d = winData;
      if (bcastCnt_q != 16'hFFFF) begin
        bcastCnt_d = bcastCnt_q + 16'd1;
      end
`ifdef CDB_ROUND_ROBIN_EN
      ptr_d = winnerIdx + 2'd1;
`endif
    end
  end

  // State registers with synchronous reset; pending requests are not
  // remembered across reset, they simply re-arbitrate afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdbValid_q <= 1'b0;
      cdbSel_q   <= 2'd0;
      cdbTag_q   <= '0;
      cdbData_q  <= '0;
      bcastCnt_q <= 16'd0;
`ifdef CDB_ROUND_ROBIN_EN
      ptr_q      <= 2'd0;
`endif
    end else begin
      cdbValid_q <= cdbValid_d;
      cdbSel_q   <= cdbSel_d;
      cdbTag_q   <= cdbTag_d;
      cdbData_q  <= cdbData_d;
      bcastCnt_q <= bcastCnt_d;
`ifdef CDB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.cdb_valid = cdbValid_q;
  assign bus.cdb_sel   = cdbSel_q;
  assign bus.cdb_tag   = cdbTag_q;
  assign bus.cdb_data  = cdbData_q;
  assign bus.bcast_cnt = bcastCnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. Directed stimulus drives requests
// one cycle at a time and checks the combinational grant directly; every
// expected broadcast is queued and a separate monitor compares it when the
// arbiter raises cdb_valid. Expected grant patterns follow
// CDB_ROUND_ROBIN_EN when it is defined for the build.
module tb_cdb_arbiter;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  typedef struct {
    logic [1:0]        sel;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [15:0]       cnt;
    int                due;
  } bcast_t;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bcast_t            sbQ[$];
  int                compared   = 0;
  int                mismatched = 0;
  int                cycleNum   = 0;
  logic [15:0]       expCnt     = 16'd0;
  logic [TAG_W-1:0]  tagVal[4];
  logic [DATA_W-1:0] dataVal[4];
  logic [TAG_W-1:0]  lastTag;
  logic [DATA_W-1:0] lastData;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Hard stop in case the run never reaches its end.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleNum);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge, then check the
  // combinational grant at the falling edge and queue the expected broadcast.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic rstVal,
                               input logic [3:0] expGrant, input string name);
    bcast_t e;
    @(posedge clk);
    #1;
    rst           = rstVal;
    bus.req       = r;
    bus.cdb_ready = rdy;
    if (rstVal) expCnt = 16'd0;
    @(negedge clk);
    checkOutput(name, {60'd0, bus.grant}, {60'd0, expGrant});
    if (expGrant != 4'b0000) begin
      case (expGrant)
        4'b0001: e.sel = 2'd0;
        4'b0010: e.sel = 2'd1;
        4'b0100: e.sel = 2'd2;
        default: e.sel = 2'd3;
      endcase
      if (expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
      e.tag    = tagVal[e.sel];
      e.data   = dataVal[e.sel];
      e.cnt    = expCnt;
      e.due    = cycleNum + 1;
      lastTag  = e.tag;
      lastData = e.data;
      sbQ.push_back(e);
    end
  endtask

  // Monitor: compare each broadcast against the oldest queued expectation,
  // and flag expectations whose cycle passes without a broadcast.
  always @(negedge clk) begin
    bcast_t e;
    if (bus.cdb_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_bcast: got cdb_valid=1 sel=%0d, expected no broadcast (cycle %0d)",
                 bus.cdb_sel, cycleNum);
      end else begin
        e = sbQ.pop_front();
        checkOutput("bcast_cycle", 64'(cycleNum), 64'(e.due));
        checkOutput("cdb_sel",   {62'd0, bus.cdb_sel},   {62'd0, e.sel});
        checkOutput("cdb_tag",   {60'd0, bus.cdb_tag},   {60'd0, e.tag});
        checkOutput("cdb_data",  {32'd0, bus.cdb_data},  {32'd0, e.data});
        checkOutput("bcast_cnt", {48'd0, bus.bcast_cnt}, {48'd0, e.cnt});
      end
    end else if (sbQ.size() != 0 && sbQ[0].due <= cycleNum) begin
      e = sbQ.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL missing_bcast: got cdb_valid=%b, expected broadcast sel=%0d (cycle %0d)",
               bus.cdb_valid, e.sel, cycleNum);
    end
  end

  initial begin
    tagVal[0] = 4'h1; dataVal[0] = 32'h11111111;
    tagVal[1] = 4'h5; dataVal[1] = 32'h22222222;
    tagVal[2] = 4'h9; dataVal[2] = 32'hDEADBEEF;
    tagVal[3] = 4'hC; dataVal[3] = 32'h44444444;
    lastTag  = '0;
    lastData = '0;
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.cdb_ready = 1'b1;
    bus.tag0  = tagVal[0]; bus.data0 = dataVal[0];
    bus.tag1  = tagVal[1]; bus.data1 = dataVal[1];
    bus.tag2  = tagVal[2]; bus.data2 = dataVal[2];
    bus.tag3  = tagVal[3]; bus.data3 = dataVal[3];

    // Reset with every FU requesting: grant must stay low.
    for (int i = 0; i < 2; i++) applyStimulus(4'b1111, 1'b1, 1'b1, 4'b0000, "grant_in_reset");
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, "grant_idle");
    checkOutput("rst_valid", {63'd0, bus.cdb_valid}, 64'd0);
    checkOutput("rst_sel",   {62'd0, bus.cdb_sel},   64'd0);
    checkOutput("rst_tag",   {60'd0, bus.cdb_tag},   64'd0);
    checkOutput("rst_data",  {32'd0, bus.cdb_data},  64'd0);
    checkOutput("rst_cnt",   {48'd0, bus.bcast_cnt}, 64'd0);

    // Single requester FU 2: broadcast tag 9 / DEADBEEF with count 1.
    applyStimulus(4'b0100, 1'b1, 1'b0, 4'b0100, "grant_single");
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, "grant_idle");

    // Reset while requests are pending clears count and pointer.
    applyStimulus(4'b1111, 1'b1, 1'b1, 4'b0000, "grant_in_reset2");
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, "grant_idle");
    checkOutput("rst2_valid", {63'd0, bus.cdb_valid}, 64'd0);
    checkOutput("rst2_sel",   {62'd0, bus.cdb_sel},   64'd0);
    checkOutput("rst2_cnt",   {48'd0, bus.bcast_cnt}, 64'd0);

    // All four requesting for five cycles.
`ifdef CDB_ROUND_ROBIN_EN
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001, "grant_all_0");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0010, "grant_all_1");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0100, "grant_all_2");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b1000, "grant_all_3");
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001, "grant_all_4");
`else
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001, "grant_all_fixed");
`endif

    // Grant FU 3, then FU 1 and FU 2 compete (skip over the idle ones).
    applyStimulus(4'b1000, 1'b1, 1'b0, 4'b1000, "grant_fu3");
    applyStimulus(4'b0110, 1'b1, 1'b0, 4'b0010, "grant_wrap_a");
`ifdef CDB_ROUND_ROBIN_EN
    applyStimulus(4'b0110, 1'b1, 1'b0, 4'b0100, "grant_wrap_b");
`else
    applyStimulus(4'b0110, 1'b1, 1'b0, 4'b0010, "grant_wrap_b");
`endif
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, "grant_idle");

    // Backpressure: three stalled cycles, broadcast holds the last values.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0000, "grant_stall");
      checkOutput("stall_valid", {63'd0, bus.cdb_valid}, 64'd0);
      checkOutput("stall_tag",   {60'd0, bus.cdb_tag},   {60'd0, lastTag});
      checkOutput("stall_data",  {32'd0, bus.cdb_data},  {32'd0, lastData});
    end
    applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0001, "grant_after_stall");
    checkOutput("stall_valid", {63'd0, bus.cdb_valid}, 64'd0);

    // Run the counter up to FFFE, then three more grants must pin it at FFFF.
    while (expCnt != 16'hFFFE) applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0001, "grant_preload");
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0001, "grant_sat");
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, "grant_idle");
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, "grant_idle");
    checkOutput("sat_cnt_hold", {48'd0, bus.bcast_cnt}, 64'hFFFF);

    @(negedge clk);
    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
